// File: rtl/shift_offset_generator.sv
// Tags AXI4S beats with the barrel-shifter offset (running byte fill level), byte count and wrap flag.
// Registered output with a 2-entry skid buffer; define SHIFT_OFFSET_KEEP_CHECK_EN for the sticky tkeep check.
module shift_offset_generator #(
  parameter int WIDTH        = 512,
  parameter int BYTES        = WIDTH/8,
  parameter int OFFSET_WIDTH = $clog2(BYTES)+1
)(
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [WIDTH-1:0]        s_tdata,
  input  logic [BYTES-1:0]        s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [WIDTH-1:0]        m_tdata,
  output logic [BYTES-1:0]        m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [OFFSET_WIDTH-1:0] m_offset,
  output logic [OFFSET_WIDTH-1:0] m_bytes,
  output logic                    m_wrap,
  output logic                    o_keep_err
);

  typedef struct packed {
    logic [WIDTH-1:0]        data;
    logic [BYTES-1:0]        keep;
    logic                    last;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [OFFSET_WIDTH-1:0] bytes;
    logic                    wrap;
  } beat_t;

  localparam logic [OFFSET_WIDTH:0] BYTES_W = (OFFSET_WIDTH+1)'(BYTES);

  function automatic logic [OFFSET_WIDTH-1:0] popcnt(input logic [BYTES-1:0] k);
    logic [OFFSET_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < BYTES; i++) c = c + OFFSET_WIDTH'(k[i]);
    return c;
  endfunction

  beat_t                   main_q, main_d, skid_q, skid_d, in_beat;
  logic                    main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic                    rdy_q, rdy_d;
  logic [OFFSET_WIDTH-1:0] fill_q, fill_d, pcnt;
  logic [OFFSET_WIDTH:0]   sum;
  logic                    accept, wrap;

  always_comb begin
    accept         = s_tvalid && rdy_q;
    pcnt           = popcnt(s_tkeep);
    sum            = {1'b0, fill_q} + {1'b0, pcnt};
    wrap           = (sum >= BYTES_W);
    in_beat.data   = s_tdata;
    in_beat.keep   = s_tkeep;
    in_beat.last   = s_tlast;
    in_beat.offset = fill_q;
    in_beat.bytes  = pcnt;
    in_beat.wrap   = wrap;

    // fill advances at acceptance so back-to-back beats chain without waiting on the output
    fill_d = fill_q;
    if (accept) begin
      if (s_tlast)   fill_d = '0;
      else if (wrap) fill_d = OFFSET_WIDTH'(sum - BYTES_W);
      else           fill_d = sum[OFFSET_WIDTH-1:0];
    end

    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || m_tready) begin
      // skid full implies rdy_q=0, so no new beat can arrive in the same cycle
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = in_beat;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      fill_q     <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      fill_q     <= fill_d;
    end
  end

`ifdef SHIFT_OFFSET_KEEP_CHECK_EN
  logic keep_err_q, keep_err_d, keep_gap;

  always_comb begin
    keep_gap   = |(s_tkeep & (s_tkeep + BYTES'(1)));
    keep_err_d = keep_err_q || (accept && keep_gap);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) keep_err_q <= 1'b0;
    else        keep_err_q <= keep_err_d;
  end

  assign o_keep_err = keep_err_q;
`else
  assign o_keep_err = 1'b0;
`endif

  assign s_tready = rdy_q;
  assign m_tvalid = main_vld_q;
  assign m_tdata  = main_q.data;
  assign m_tkeep  = main_q.keep;
  assign m_tlast  = main_q.last;
  assign m_offset = main_q.offset;
  assign m_bytes  = main_q.bytes;
  assign m_wrap   = main_q.wrap;

endmodule

// File: tb/tb_shift_offset_generator.sv
// Directed bench for shift_offset_generator at WIDTH=512 (64 bytes per beat).
module tb_shift_offset_generator;
  localparam int WIDTH = 512;
  localparam int BYTES = 64;
  localparam int OW    = 7;
`ifdef SHIFT_OFFSET_KEEP_CHECK_EN
  localparam bit KC = 1'b1;
`else
  localparam bit KC = 1'b0;
`endif

  logic              aclk = 1'b0, areset = 1'b1;
  logic [WIDTH-1:0]  s_tdata = '0, m_tdata;
  logic [BYTES-1:0]  s_tkeep = '0, m_tkeep;
  logic              s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
  logic              m_tlast, m_tvalid, m_tready = 1'b1;
  logic [OW-1:0]     m_offset, m_bytes;
  logic              m_wrap, o_keep_err;
  int                checks = 0, errors = 0;

  always #5 aclk = ~aclk;

  shift_offset_generator #(.WIDTH(WIDTH)) dut (
    .aclk(aclk), .areset(areset),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_offset(m_offset), .m_bytes(m_bytes), .m_wrap(m_wrap), .o_keep_err(o_keep_err)
  );

  task automatic chk(input string name, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [BYTES-1:0] kmask(input int n);
    logic [BYTES-1:0] one;
    one = 1;
    if (n >= BYTES) return '1;
    return (one << n) - one;
  endfunction

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  // drive one beat, wait for acceptance, then leave it sitting in the output register
  task automatic send(input logic [BYTES-1:0] keep, input bit last, input logic [WIDTH-1:0] data);
    int n;
    n = 0;
    s_tvalid = 1'b1; s_tkeep = keep; s_tlast = last; s_tdata = data;
    while (!s_tready && n < 20) begin tick(); n++; end
    chk("accept_timeout", WIDTH'(n < 20), WIDTH'(1));
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic expect_out(input string name, input int off, input int nb, input bit wr, input bit last);
    chk({name, "_vld"},  WIDTH'(m_tvalid), WIDTH'(1));
    chk({name, "_off"},  WIDTH'(m_offset), WIDTH'(off));
    chk({name, "_byt"},  WIDTH'(m_bytes),  WIDTH'(nb));
    chk({name, "_wrap"}, WIDTH'(m_wrap),   WIDTH'(wr));
    chk({name, "_last"}, WIDTH'(m_tlast),  WIDTH'(last));
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_rdy",  WIDTH'(s_tready), '0);
    chk("rst_vld",  WIDTH'(m_tvalid), '0);
    chk("rst_off",  WIDTH'(m_offset), '0);
    chk("rst_byt",  WIDTH'(m_bytes),  '0);
    chk("rst_wrap", WIDTH'(m_wrap),   '0);
    chk("rst_last", WIDTH'(m_tlast),  '0);
    chk("rst_err",  WIDTH'(o_keep_err), '0);
    chk("rst_data", m_tdata, '0);
    chk("rst_keep", WIDTH'(m_tkeep), '0);
    areset = 1'b0;
    chk("rdy_pre_edge", WIDTH'(s_tready), '0);
    tick();
    chk("rdy_post_edge", WIDTH'(s_tready), WIDTH'(1));

    // 1: 10, 20, 40 bytes, last on third; next packet restarts at 0
    send(kmask(10), 1'b0, WIDTH'(512'hA1));
    expect_out("p1b0", 0, 10, 1'b0, 1'b0);
    chk("p1b0_data", m_tdata, WIDTH'(512'hA1));
    chk("p1b0_keep", WIDTH'(m_tkeep), WIDTH'(kmask(10)));
    send(kmask(20), 1'b0, WIDTH'(512'hA2));
    expect_out("p1b1", 10, 20, 1'b0, 1'b0);
    send(kmask(40), 1'b1, WIDTH'(512'hA3));
    expect_out("p1b2", 30, 40, 1'b1, 1'b1);
    send(kmask(5), 1'b1, WIDTH'(512'hA4));
    expect_out("p1next", 0, 5, 1'b0, 1'b1);

    // 2: full beats
    send('1, 1'b0, WIDTH'(512'hB1));
    expect_out("full0", 0, 64, 1'b1, 1'b0);
    send('1, 1'b0, WIDTH'(512'hB2));
    expect_out("full1", 0, 64, 1'b1, 1'b0);
    send('1, 1'b1, WIDTH'(512'hB3));
    expect_out("full2", 0, 64, 1'b1, 1'b1);

    // 3: empty beat at fill 17
    send(kmask(17), 1'b0, WIDTH'(512'hC1));
    expect_out("z_pre", 0, 17, 1'b0, 1'b0);
    send('0, 1'b0, WIDTH'(512'hC2));
    expect_out("z_beat", 17, 0, 1'b0, 1'b0);
    send(kmask(47), 1'b1, WIDTH'(512'hC3));
    expect_out("z_post", 17, 47, 1'b1, 1'b1);
    tick();
    chk("z_drain", WIDTH'(m_tvalid), '0);

    // 4: backpressure for 5 cycles with continuous valid
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tkeep = kmask(8); s_tlast = 1'b0; s_tdata = WIDTH'(512'hD0);
    tick();
    chk("bp_acc0_rdy", WIDTH'(s_tready), WIDTH'(1));
    s_tdata = WIDTH'(512'hD1);
    tick();
    chk("bp_rdy_drop", WIDTH'(s_tready), '0);
    s_tdata = WIDTH'(512'hD2);
    for (int c = 0; c < 4; c++) begin
      chk("bp_hold_vld",  WIDTH'(m_tvalid), WIDTH'(1));
      chk("bp_hold_data", m_tdata, WIDTH'(512'hD0));
      chk("bp_hold_off",  WIDTH'(m_offset), '0);
      chk("bp_hold_rdy",  WIDTH'(s_tready), '0);
      if (c < 3) tick();
    end
    m_tready = 1'b1;
    tick();
    chk("bp_rel0_data", m_tdata, WIDTH'(512'hD1));
    chk("bp_rel0_off",  WIDTH'(m_offset), WIDTH'(8));
    chk("bp_rel0_rdy",  WIDTH'(s_tready), WIDTH'(1));
    tick();
    s_tvalid = 1'b0;
    chk("bp_rel1_data", m_tdata, WIDTH'(512'hD2));
    chk("bp_rel1_off",  WIDTH'(m_offset), WIDTH'(16));
    chk("bp_rel1_vld",  WIDTH'(m_tvalid), WIDTH'(1));
    tick();
    chk("bp_empty", WIDTH'(m_tvalid), '0);
    send(kmask(16), 1'b1, WIDTH'(512'hD3));
    expect_out("bp_tail", 24, 16, 1'b0, 1'b1);

    // 5: reset mid-packet at fill 40
    send(kmask(40), 1'b0, WIDTH'(512'hE1));
    expect_out("r_pre", 0, 40, 1'b0, 1'b0);
    m_tready = 1'b0;
    #2 areset = 1'b1;
    #1;
    chk("r_vld",  WIDTH'(m_tvalid), '0);
    chk("r_rdy",  WIDTH'(s_tready), '0);
    chk("r_off",  WIDTH'(m_offset), '0);
    chk("r_data", m_tdata, '0);
    tick();
    areset = 1'b0;
    m_tready = 1'b1;
    send(kmask(5), 1'b0, WIDTH'(512'hE2));
    expect_out("r_post", 0, 5, 1'b0, 1'b0);
    send(kmask(1), 1'b1, WIDTH'(512'hE3));
    expect_out("r_post2", 5, 1, 1'b0, 1'b1);

    // 6: non-contiguous keep
    chk("kc_pre", WIDTH'(o_keep_err), '0);
    send(BYTES'(64'h5), 1'b1, WIDTH'(512'hF1));
    expect_out("kc_beat", 0, 2, 1'b0, 1'b1);
    chk("kc_err", WIDTH'(o_keep_err), WIDTH'(KC));
    send(kmask(3), 1'b1, WIDTH'(512'hF2));
    expect_out("kc_next", 0, 3, 1'b0, 1'b1);
    chk("kc_sticky", WIDTH'(o_keep_err), WIDTH'(KC));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
